// File: rtl/disp_scan_arbiter_pkg.sv
// Shared encodings for the display scan arbiter: source modes, FSM states and
// the active-low BCD-to-segment table ({g,f,e,d,c,b,a}).
package disp_scan_arbiter_pkg;

   localparam logic [1:0] MODE_TIME  = 2'd0;
   localparam logic [1:0] MODE_ALARM = 2'd1;
   localparam logic [1:0] MODE_WATCH = 2'd2;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // State encodings equal the mode encodings, so the FSM state is the mode.
   typedef enum logic [1:0] {
      S_TIME  = MODE_TIME,
      S_ALARM = MODE_ALARM,
      S_WATCH = MODE_WATCH
   } state_e;

   // Entry [n] is the pattern for BCD digit n.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/disp_scan_arbiter_if.sv
// Requester/display bus of the scan arbiter: enables, key, ring request,
// the three BCD sources, blink mask, and the effective mode and pin outputs.
interface disp_scan_arbiter_if;
   logic        en;
   logic        mode_key;
   logic        ring_req;
   logic [15:0] src_time;
   logic [15:0] src_alarm;
   logic [15:0] src_watch;
   logic [3:0]  blink_mask;
   logic [1:0]  mode_o;
   logic [3:0]  sel;
   logic [6:0]  seg;

   modport master (
      output en, mode_key, ring_req, src_time, src_alarm, src_watch, blink_mask,
      input  mode_o, sel, seg
   );

   modport slave (
      input  en, mode_key, ring_req, src_time, src_alarm, src_watch, blink_mask,
      output mode_o, sel, seg
   );
endinterface

// File: rtl/disp_scan_arbiter_bcd7seg_dec.sv
// Combinational nibble-to-segment decoder; non-BCD nibbles (A-F) are blank.
module bcd7seg_dec
   import disp_scan_arbiter_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (nib < 4'd10) seg = SEG_TABLE[nib];
   end

endmodule

// File: rtl/disp_scan_arbiter.sv
// Arbitrates three BCD requesters onto one 4-digit multiplexed display with
// per-frame snapshots. Optional digit blinking is built when DISP_BLINK_EN is defined.
module disp_scan_arbiter
   import disp_scan_arbiter_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLINK_DIV = 12500000
) (
   input  logic               clk_50mhz,
   input  logic               rst,
   disp_scan_arbiter_if.slave bus
);

   if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("SCAN_DIV must be at least 2");
   end
   if (BLINK_DIV < 1) begin : g_bad_blink_div
      $error("BLINK_DIV must be at least 1");
   end

   localparam int unsigned SCW = $clog2(SCAN_DIV);
   localparam logic [SCW-1:0] SCAN_MAX = SCW'(SCAN_DIV - 1);

   state_e           state;
   logic             key_q;
   logic [SCW-1:0]   scan_cnt;
   logic [1:0]       idx;
   logic [15:0]      fbuf;

   logic             tick;
   logic             key_edge;
   logic [1:0]       eff_mode;
   logic [15:0]      eff_src;
   logic [3:0]       nib;
   logic [6:0]       dec_seg;
   logic             blank_slot;

   always_comb begin
      tick     = (scan_cnt == SCAN_MAX);
      key_edge = bus.mode_key & ~key_q;
      eff_mode = bus.ring_req ? MODE_TIME : 2'(state);
      case (eff_mode)
         MODE_ALARM: eff_src = bus.src_alarm;
         MODE_WATCH: eff_src = bus.src_watch;
         default:    eff_src = bus.src_time;
      endcase
      nib = fbuf[{idx, 2'b00} +: 4];
   end

   bcd7seg_dec u_dec (
      .nib (nib),
      .seg (dec_seg)
   );

   // Mode FSM: a ringing alarm swallows key edges, so the selection survives it.
   always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
         state <= S_TIME;
         key_q <= 1'b0;
      end else begin
         key_q <= bus.mode_key;
         if (key_edge && !bus.ring_req) begin
            case (state)
               S_TIME:  state <= S_ALARM;
               S_ALARM: state <= S_WATCH;
               default: state <= S_TIME;
            endcase
         end
      end
   end

   // Frame buffer reloads only as the scan wraps from d3 to d0, so a frame never tears.
   always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
         scan_cnt <= '0;
         idx      <= '0;
         fbuf     <= '1;
      end else begin
         scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
         if (tick) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) fbuf <= eff_src;
         end
      end
   end

`ifdef DISP_BLINK_EN
   localparam int unsigned BKW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BKW-1:0] BLINK_MAX = BKW'(BLINK_DIV - 1);

   logic [BKW-1:0] blink_cnt;
   logic           phase;

   always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == BLINK_MAX) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   always_comb blank_slot = phase & (bus.ring_req | bus.blink_mask[idx]);
`else
   always_comb blank_slot = 1'b0;
`endif

   always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
         bus.mode_o <= MODE_TIME;
         bus.sel    <= 4'b1110;
         bus.seg    <= SEG_BLANK;
      end else begin
         bus.mode_o <= eff_mode;
         bus.sel    <= bus.en ? ~(4'b0001 << idx) : '1;
         bus.seg    <= blank_slot ? SEG_BLANK : dec_seg;
      end
   end

endmodule

// File: doc/disp_scan_arbiter.md
Name: disp_scan_arbiter

Overview:
Shares the board's single 4-digit multiplexed 7-segment display between three BCD display requesters: time, alarm-set and stopwatch. Arbitrates by a user mode key, with priority override while the alarm rings. Generates the digit-scan sequence and a tear-free frame snapshot. Sits between the clock/alarm/stopwatch counters and the sel/seg pins in the top level.

Parameters:
SCAN_DIV, 50000, clk_50mhz cycles per digit slot (1 kHz digit rate, 250 Hz frame); legal range >= 2.
BLINK_DIV, 12500000, cycles per blink half-period (2 Hz blink at 50 MHz); used only with the blink feature.

Ports:
clk_50mhz  input  1   system clock, 50 MHz
rst        input  1   asynchronous, active-low reset
en         input  1   display enable; 0 = all digits dark, scanning continues
mode_key   input  1   debounced mode key level; rising edge advances the mode
ring_req   input  1   alarm ringing; forces TIME source and locks the mode
src_time   input  16  4 BCD digits {d3,d2,d1,d0}, d0 = rightmost
src_alarm  input  16  as above
src_watch  input  16  as above
blink_mask input  4   per-digit blink select (used only with the blink feature)
mode_o     output 2   effective source: 0 TIME, 1 ALARM, 2 WATCH
sel        output 4   digit enables, active-low one-hot, sel[0] = d0
seg        output 7   {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (async, rst=0) values: mode=TIME; mode_o=0; digit index=0; scan counter=0; frame buffer=16'hFFFF (blank); sel=4'b1110; seg=7'h7F. Mid-frame reset returns to these values immediately.
- Mode FSM states: S_TIME -> S_ALARM -> S_WATCH -> S_TIME.
  - Advances one state per mode_key rising edge, detected against a 1-cycle registered copy.
  - The mode register updates on the cycle after the edge.
  - While ring_req=1, key edges are discarded and the mode register holds.
  - Same-cycle ring_req and key edge: ring_req wins and the edge is lost.
- Effective source = TIME if ring_req=1, else the mode register. mode_o = effective source, registered, 1-cycle latency.
- Scan counter:
  - Counts 0..SCAN_DIV-1; terminal count produces a 1-cycle tick and wraps to 0.
  - On each tick, digit index increments mod 4 (3 wraps to 0).
- Frame snapshot: on a tick where the index wraps 3->0, the frame buffer loads the effective source's 16 bits. Digits never tear within a frame. Source or mode changes appear at the next frame start.
- Output timing:
  - sel and seg are registered and update on the cycle after a tick.
  - sel = ~(1 << index) when en=1; 4'hF when en=0.
  - seg = decode of buffer nibble[index].
- Decode: BCD 0-9 to standard patterns (0 = 7'h40, 1 = 7'h79, 8 = 7'h00, 9 = 7'h10). Nibbles A-F decode to blank (7'h7F).
- en only gates sel. The counter, index and snapshot run regardless of en.

Optional Feature:
DISP_BLINK_EN
- Defined:
  - A blink counter of BLINK_DIV cycles toggles a phase bit; reset phase = 0 (visible).
  - When phase=1, digit slots whose blink_mask bit is set drive seg=7'h7F; sel is unaffected.
  - blink_mask is sampled live, not snapshotted.
  - While ring_req=1, all four digits blink regardless of blink_mask.
- Undefined: blink_mask is ignored, no blink counter exists, and seg is always the decoded value.

Decomposition:
- Shared package: mode encodings (MODE_TIME=0, MODE_ALARM=1, MODE_WATCH=2), SEG_BLANK=7'h7F, the BCD-to-segment constant table.
- One sub-module, bcd7seg_dec: combinational nibble-to-seg decoder, instantiated once on the selected nibble.

Test Plan:
All scenarios use SCAN_DIV=4 and BLINK_DIV=16.
1. Reset then release; src_time=16'h1234; run 20 cycles -> sel walks 1110, 1101, 1011, 0111 at 4-cycle spacing; seg blank for the first frame; after the 3->0 wrap, d0 shows 4 (7'h19), d1 shows 3 (7'h30).
2. Pulse mode_key high 3 times, frame-spaced -> mode_o 1, 2, 0; seg follows src_alarm, src_watch, src_time, each from the next frame start.
3. Hold ring_req=1 in WATCH and pulse mode_key -> mode_o=0 and src_time displayed. Release ring_req -> mode_o=2, WATCH restored.
4. Change src_time from 16'h0000 to 16'h9999 mid-frame -> the remaining digits of the current frame still show 0; the next frame shows all 9 (7'h10).
5. en=0 for one frame -> sel=4'hF throughout; index keeps advancing, so on en=1 the scan resumes at the expected digit. src=16'h00AF -> d1, d0 blank.
6. With DISP_BLINK_EN, blink_mask=4'b0001 -> d0 seg alternates decoded/7'h7F every 16 cycles while d1-d3 stay steady. Assert rst mid-blink -> all outputs return to reset values.
